// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared codes and helpers for the parametrised register file
package reg_file_pkg;

    typedef enum logic [1:0] {
        T_HOLD  = 2'b00,
        T_LOAD  = 2'b01,
        T_ACCUM = 2'b10,
        T_CLEAR = 2'b11
    } t_acc_mode_e;

    typedef enum logic {
        SRC_ACC = 1'b0,
        SRC_DM  = 1'b1
    } gpr_src_e;

    function automatic int nelem(input int tdim);
        return tdim * tdim;
    endfunction

    // Operands arrive sign-extended to 64 bits; the result is clamped to a w-bit signed range.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic signed [64:0] sum;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sum = $signed({a[63], a}) + $signed({b[63], b});
        hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo  = -(65'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi[63:0];
        end else if (sum < lo) begin
            return lo[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/tensor_loader.sv
// rtl/tensor_loader.sv - self-indexing tensor register: element array, index counter, full flag
module tensor_loader #(
    parameter int DATA_W = 16,
    parameter int NELEM  = 9,
    localparam int IDX_W = (NELEM > 1) ? $clog2(NELEM) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    clr_idx,
    input  logic [DATA_W-1:0]       din,
    output logic [NELEM*DATA_W-1:0] data,
    output logic                    full
);

    logic [DATA_W-1:0] elem [NELEM];
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            full <= 1'b0;
            for (int i = 0; i < NELEM; i++) begin
                elem[i] <= '0;
            end
        end else if (clr_idx) begin
            // Index reset wins over a same-cycle load; contents are kept.
            idx  <= '0;
            full <= 1'b0;
        end else if (load) begin
            elem[idx] <= din;
            if (idx == IDX_W'(NELEM - 1)) begin
                idx  <= '0;
                full <= 1'b1;
            end else begin
                idx  <= idx + 1'b1;
                full <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NELEM; i++) begin : g_flat
        assign data[i*DATA_W +: DATA_W] = elem[i];
    end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - accumulator, GPR bank, bounded stack pointer, tensor registers and tensor accumulator
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                NUM_GPR     = 4,
    parameter int                TDIM        = 3,
    parameter logic [DATA_W-1:0] STACK_BASE  = DATA_W'(16'hFFFF),
    parameter int                STACK_DEPTH = 64,
    parameter int                SATURATE    = 0,
    localparam int               AW          = $clog2(NUM_GPR),
    localparam int               NELEM       = nelem(TDIM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic [DATA_W-1:0]       dm_out,
    input  logic                    acc_wr,
    input  logic                    gpr_wr,
    input  logic                    gpr_src,
    input  logic [AW-1:0]           gpr_waddr,
    input  logic [AW-1:0]           gpr_raddr0,
    input  logic [AW-1:0]           gpr_raddr1,
    output logic [DATA_W-1:0]       gpr_rdata0,
    output logic [DATA_W-1:0]       gpr_rdata1,
    output logic [DATA_W-1:0]       acc_out,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       sp_out,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    stack_err,
    input  logic                    load_a,
    input  logic                    load_b,
    input  logic                    t_clr_idx,
    output logic [NELEM*DATA_W-1:0] a_out,
    output logic [NELEM*DATA_W-1:0] b_out,
    output logic                    a_full,
    output logic                    b_full,
    input  logic [NELEM*DATA_W-1:0] mxu_out,
    input  logic [1:0]              t_acc_mode,
    output logic [NELEM*DATA_W-1:0] t_acc_out
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] gpr_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_wr) begin
            acc <= alu_out;
        end
    end

    assign acc_out = acc;

    // Source is the registered acc, so a same-cycle acc_wr is not seen by the GPR write.
    assign gpr_wdata = (gpr_src == SRC_DM) ? dm_out : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_wr) begin
            gpr[gpr_waddr] <= gpr_wdata;
        end
    end

    assign gpr_rdata0 = (gpr_wr && (gpr_waddr == gpr_raddr0)) ? gpr_wdata : gpr[gpr_raddr0];
    assign gpr_rdata1 = (gpr_wr && (gpr_waddr == gpr_raddr1)) ? gpr_wdata : gpr[gpr_raddr1];

    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] sp_next;
    logic              err_set;

    assign stack_empty = (sp == STACK_BASE);
    assign stack_full  = ((STACK_BASE - sp) == DATA_W'(STACK_DEPTH));
    assign sp_out      = sp;

    always_comb begin
        sp_next = sp;
        err_set = 1'b0;
        if (push && !pop) begin
            if (stack_full) begin
                err_set = 1'b1;
            end else begin
                sp_next = sp - 1'b1;
            end
        end else if (pop && !push) begin
            if (stack_empty) begin
                err_set = 1'b1;
            end else begin
                sp_next = sp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= STACK_BASE;
            stack_err <= 1'b0;
        end else begin
            sp <= sp_next;
            if (err_set) begin
                stack_err <= 1'b1;
            end else if (err_clr) begin
                stack_err <= 1'b0;
            end
        end
    end

    tensor_loader #(
        .DATA_W (DATA_W),
        .NELEM  (NELEM)
    ) u_tensor_a (
        .clk     (clk),
        .reset   (reset),
        .load    (load_a),
        .clr_idx (t_clr_idx),
        .din     (dm_out),
        .data    (a_out),
        .full    (a_full)
    );

    tensor_loader #(
        .DATA_W (DATA_W),
        .NELEM  (NELEM)
    ) u_tensor_b (
        .clk     (clk),
        .reset   (reset),
        .load    (load_b),
        .clr_idx (t_clr_idx),
        .din     (dm_out),
        .data    (b_out),
        .full    (b_full)
    );

    logic [NELEM*DATA_W-1:0] t_acc;
    logic [NELEM*DATA_W-1:0] t_acc_next;
    logic [NELEM*DATA_W-1:0] t_sum;

    for (genvar i = 0; i < NELEM; i++) begin : g_lane
        logic [DATA_W-1:0] lane_acc;
        logic [DATA_W-1:0] lane_mxu;
        assign lane_acc = t_acc[i*DATA_W +: DATA_W];
        assign lane_mxu = mxu_out[i*DATA_W +: DATA_W];
        if (SATURATE != 0) begin : g_sat
            assign t_sum[i*DATA_W +: DATA_W] = DATA_W'(sat_add(
                {{(64-DATA_W){lane_acc[DATA_W-1]}}, lane_acc},
                {{(64-DATA_W){lane_mxu[DATA_W-1]}}, lane_mxu},
                DATA_W));
        end else begin : g_wrap
            assign t_sum[i*DATA_W +: DATA_W] = lane_acc + lane_mxu;
        end
    end

    always_comb begin
        t_acc_next = t_acc;
        case (t_acc_mode_e'(t_acc_mode))
            T_HOLD:  t_acc_next = t_acc;
            T_LOAD:  t_acc_next = mxu_out;
            T_ACCUM: t_acc_next = t_sum;
            T_CLEAR: t_acc_next = '0;
            default: t_acc_next = t_acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_acc <= '0;
        end else begin
            t_acc <= t_acc_next;
        end
    end

    assign t_acc_out = t_acc;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param (wrapping and saturating instances)
module tb_reg_file_param;

    localparam int W  = 144;
    localparam int DW = 16;

    typedef enum int {
        S_ACC, S_RD0, S_RD1, S_SP, S_FULL, S_EMPTY, S_ERR,
        S_AOUT, S_AFULL, S_BOUT, S_BFULL, S_TACC, S_TACC_SAT
    } sel_e;

    typedef struct {
        string        name;
        sel_e         sel;
        logic [W-1:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] alu_out = '0, dm_out = '0;
    logic          acc_wr = 0, gpr_wr = 0, gpr_src = 0;
    logic [1:0]    gpr_waddr = '0, gpr_raddr0 = '0, gpr_raddr1 = '0;
    logic          push = 0, pop = 0, err_clr = 0;
    logic          load_a = 0, load_b = 0, t_clr_idx = 0;
    logic [W-1:0]  mxu_out = '0;
    logic [1:0]    t_acc_mode = 2'b00;

    logic [DW-1:0] gpr_rdata0, gpr_rdata1, acc_out, sp_out;
    logic          stack_full, stack_empty, stack_err, a_full, b_full;
    logic [W-1:0]  a_out, b_out, t_acc_out;

    logic [DW-1:0] s_rdata0, s_rdata1, s_acc_out, s_sp_out;
    logic          s_stack_full, s_stack_empty, s_stack_err, s_a_full, s_b_full;
    logic [W-1:0]  s_a_out, s_b_out, s_t_acc_out;

    always #5 clk = ~clk;

    reg_file_param #(.SATURATE(0)) dut (
        .clk(clk), .reset(reset), .alu_out(alu_out), .dm_out(dm_out),
        .acc_wr(acc_wr), .gpr_wr(gpr_wr), .gpr_src(gpr_src), .gpr_waddr(gpr_waddr),
        .gpr_raddr0(gpr_raddr0), .gpr_raddr1(gpr_raddr1),
        .gpr_rdata0(gpr_rdata0), .gpr_rdata1(gpr_rdata1), .acc_out(acc_out),
        .push(push), .pop(pop), .err_clr(err_clr), .sp_out(sp_out),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err),
        .load_a(load_a), .load_b(load_b), .t_clr_idx(t_clr_idx),
        .a_out(a_out), .b_out(b_out), .a_full(a_full), .b_full(b_full),
        .mxu_out(mxu_out), .t_acc_mode(t_acc_mode), .t_acc_out(t_acc_out)
    );

    reg_file_param #(.SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .alu_out(alu_out), .dm_out(dm_out),
        .acc_wr(acc_wr), .gpr_wr(gpr_wr), .gpr_src(gpr_src), .gpr_waddr(gpr_waddr),
        .gpr_raddr0(gpr_raddr0), .gpr_raddr1(gpr_raddr1),
        .gpr_rdata0(s_rdata0), .gpr_rdata1(s_rdata1), .acc_out(s_acc_out),
        .push(push), .pop(pop), .err_clr(err_clr), .sp_out(s_sp_out),
        .stack_full(s_stack_full), .stack_empty(s_stack_empty), .stack_err(s_stack_err),
        .load_a(load_a), .load_b(load_b), .t_clr_idx(t_clr_idx),
        .a_out(s_a_out), .b_out(s_b_out), .a_full(s_a_full), .b_full(s_b_full),
        .mxu_out(mxu_out), .t_acc_mode(t_acc_mode), .t_acc_out(s_t_acc_out)
    );

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [W-1:0] actual(input sel_e sel);
        case (sel)
            S_ACC:      return W'(acc_out);
            S_RD0:      return W'(gpr_rdata0);
            S_RD1:      return W'(gpr_rdata1);
            S_SP:       return W'(sp_out);
            S_FULL:     return W'(stack_full);
            S_EMPTY:    return W'(stack_empty);
            S_ERR:      return W'(stack_err);
            S_AOUT:     return a_out;
            S_AFULL:    return W'(a_full);
            S_BOUT:     return b_out;
            S_BFULL:    return W'(b_full);
            S_TACC:     return t_acc_out;
            S_TACC_SAT: return s_t_acc_out;
            default:    return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [W-1:0] act;
            e   = sb.pop_front();
            act = actual(e.sel);
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_val(input string name, input sel_e sel, input logic [W-1:0] val);
        sb.push_back('{name, sel, val});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] fill(input logic [DW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < 9; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    logic [W-1:0] a_exp, b_exp;

    initial begin
        tick();
        tick();
        expect_val("rst_acc", S_ACC, '0);
        expect_val("rst_sp", S_SP, W'(16'hFFFF));
        expect_val("rst_empty", S_EMPTY, W'(1));
        expect_val("rst_full", S_FULL, '0);
        expect_val("rst_err", S_ERR, '0);
        expect_val("rst_afull", S_AFULL, '0);
        expect_val("rst_aout", S_AOUT, '0);
        expect_val("rst_tacc", S_TACC, '0);
        reset = 1'b0;

        // Partial tensor load aborted by reset, then a clean 9-element load.
        for (int i = 0; i < 4; i++) begin
            dm_out = 16'h00A0 + 16'(i);
            load_a = 1'b1;
            tick();
        end
        load_a = 1'b0;
        reset  = 1'b1;
        expect_val("midrst_afull", S_AFULL, '0);
        expect_val("midrst_aout", S_AOUT, '0);
        tick();
        reset = 1'b0;
        a_exp = '0;
        for (int i = 1; i <= 9; i++) begin
            dm_out = 16'(i);
            load_a = 1'b1;
            a_exp[(i-1)*DW +: DW] = 16'(i);
            tick();
            expect_val($sformatf("afull_after_%0d", i), S_AFULL, W'(i == 9));
        end
        expect_val("aout_1to9", S_AOUT, a_exp);
        dm_out = 16'h0077;
        tick();
        load_a = 1'b0;
        a_exp[0 +: DW] = 16'h0077;
        expect_val("afull_cleared_reload", S_AFULL, '0);
        expect_val("aout_reload_e0", S_AOUT, a_exp);

        // GPR write-through bypass and pre-edge accumulator capture.
        alu_out = 16'h1234;
        acc_wr  = 1'b1;
        tick();
        expect_val("acc_1234", S_ACC, W'(16'h1234));
        alu_out    = 16'h5555;
        gpr_wr     = 1'b1;
        gpr_src    = 1'b0;
        gpr_waddr  = 2'd2;
        gpr_raddr0 = 2'd2;
        gpr_raddr1 = 2'd1;
        expect_val("rd0_bypass", S_RD0, W'(16'h1234));
        expect_val("rd1_other", S_RD1, '0);
        tick();
        acc_wr = 1'b0;
        gpr_wr = 1'b0;
        expect_val("rd0_after", S_RD0, W'(16'h1234));
        expect_val("acc_5555", S_ACC, W'(16'h5555));
        gpr_wr     = 1'b1;
        gpr_src    = 1'b1;
        dm_out     = 16'hBEEF;
        gpr_waddr  = 2'd1;
        expect_val("rd1_dm_bypass", S_RD1, W'(16'hBEEF));
        tick();
        gpr_wr = 1'b0;
        expect_val("rd1_dm_after", S_RD1, W'(16'hBEEF));
        expect_val("rd0_kept", S_RD0, W'(16'h1234));

        // Stack: fill to depth, overflow, clear, simultaneous ops, drain, underflow.
        push = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) begin
                expect_val("sp_63", S_SP, W'(16'hFFC0));
                expect_val("full_63", S_FULL, '0);
            end
        end
        expect_val("sp_64", S_SP, W'(16'hFFBF));
        expect_val("full_64", S_FULL, W'(1));
        expect_val("empty_64", S_EMPTY, '0);
        expect_val("err_64", S_ERR, '0);
        tick();
        push = 1'b0;
        expect_val("sp_overflow", S_SP, W'(16'hFFBF));
        expect_val("err_overflow", S_ERR, W'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        expect_val("err_cleared", S_ERR, '0);
        push = 1'b1;
        pop  = 1'b1;
        tick();
        expect_val("sp_pushpop_full", S_SP, W'(16'hFFBF));
        expect_val("err_pushpop_full", S_ERR, '0);
        pop     = 1'b0;
        err_clr = 1'b1;
        tick();
        expect_val("err_set_wins_clr", S_ERR, W'(1));
        push = 1'b0;
        tick();
        err_clr = 1'b0;
        expect_val("err_cleared2", S_ERR, '0);
        pop = 1'b1;
        repeat (64) tick();
        expect_val("sp_drained", S_SP, W'(16'hFFFF));
        expect_val("empty_drained", S_EMPTY, W'(1));
        expect_val("err_drained", S_ERR, '0);
        tick();
        expect_val("sp_underflow", S_SP, W'(16'hFFFF));
        expect_val("err_underflow", S_ERR, W'(1));
        push = 1'b1;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        expect_val("sp_pushpop_empty", S_SP, W'(16'hFFFF));
        expect_val("err_sticky", S_ERR, W'(1));

        // Tensor accumulator: wrap vs saturate.
        mxu_out    = fill(16'h7FFF);
        t_acc_mode = 2'b01;
        tick();
        expect_val("tacc_load", S_TACC, fill(16'h7FFF));
        expect_val("tacc_sat_load", S_TACC_SAT, fill(16'h7FFF));
        mxu_out    = fill(16'h0001);
        t_acc_mode = 2'b10;
        tick();
        expect_val("tacc_wrap_pos", S_TACC, fill(16'h8000));
        expect_val("tacc_sat_pos", S_TACC_SAT, fill(16'h7FFF));
        mxu_out    = fill(16'h8000);
        t_acc_mode = 2'b01;
        tick();
        t_acc_mode = 2'b10;
        tick();
        expect_val("tacc_wrap_neg", S_TACC, fill(16'h0000));
        expect_val("tacc_sat_neg", S_TACC_SAT, fill(16'h8000));
        mxu_out    = fill(16'h0005);
        t_acc_mode = 2'b01;
        tick();
        mxu_out    = fill(16'hFFFE);
        t_acc_mode = 2'b10;
        tick();
        expect_val("tacc_wrap_small", S_TACC, fill(16'h0003));
        expect_val("tacc_sat_small", S_TACC_SAT, fill(16'h0003));
        mxu_out    = fill(16'h1234);
        t_acc_mode = 2'b00;
        tick();
        expect_val("tacc_hold", S_TACC, fill(16'h0003));
        t_acc_mode = 2'b11;
        tick();
        t_acc_mode = 2'b00;
        expect_val("tacc_clear", S_TACC, '0);
        expect_val("tacc_sat_clear", S_TACC_SAT, '0);

        // Index clear beats a simultaneous load; contents kept.
        b_exp  = '0;
        load_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dm_out = 16'h0011 * 16'(i + 1);
            b_exp[i*DW +: DW] = 16'h0011 * 16'(i + 1);
            tick();
        end
        dm_out    = 16'h0044;
        t_clr_idx = 1'b1;
        tick();
        t_clr_idx = 1'b0;
        load_b    = 1'b0;
        expect_val("bout_clr_drop", S_BOUT, b_exp);
        expect_val("bfull_clr", S_BFULL, '0);
        expect_val("aout_retained", S_AOUT, a_exp);
        dm_out = 16'h0055;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        b_exp[0 +: DW] = 16'h0055;
        expect_val("bout_restart_e0", S_BOUT, b_exp);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            failures++;
            checks++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the processor's fixed 16-bit register file.
- Contains an accumulator, an N-entry general-purpose register bank with two read ports, and a bounded stack pointer with full/empty/error flags.
- Contains two self-indexing TDIM×TDIM tensor registers and a tensor accumulator with load/accumulate/clear modes and optional signed saturation.
- Sits between the control unit, ALU, MXU and data memory.

Parameters:
- DATA_W, 16, scalar/element width in bits.
- NUM_GPR, 4, number of general registers; power of two, ≥2.
- TDIM, 3, tensor side; NELEM = TDIM*TDIM elements.
- STACK_BASE, 16'hFFFF, SP reset value (empty position); stack grows down.
- STACK_DEPTH, 64, maximum number of pushed entries.
- SATURATE, 0, 1 = tensor accumulate saturates signed; 0 = wraps.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- alu_out  in  DATA_W  ALU result.
- dm_out  in  DATA_W  data-memory read data.
- acc_wr  in  1  acc <= alu_out.
- gpr_wr  in  1  GPR write enable.
- gpr_src  in  1  write source: 0 = acc_out, 1 = dm_out.
- gpr_waddr  in  clog2(NUM_GPR)  write address.
- gpr_raddr0, gpr_raddr1  in  clog2(NUM_GPR)  read addresses.
- gpr_rdata0, gpr_rdata1  out  DATA_W  read data.
- acc_out  out  DATA_W  accumulator.
- push, pop  in  1  stack operations.
- err_clr  in  1  clears stack_err.
- sp_out  out  DATA_W  stack pointer.
- stack_full, stack_empty  out  1  stack status flags.
- stack_err  out  1  sticky overflow/underflow flag.
- load_a, load_b  in  1  write dm_out into the next tensor element.
- t_clr_idx  in  1  reset tensor indices and full flags.
- a_out, b_out  out  NELEM*DATA_W  tensors; element 0 in the LSBs.
- a_full, b_full  out  1  all NELEM elements loaded.
- mxu_out  in  NELEM*DATA_W  MXU result.
- t_acc_mode  in  2  00 hold, 01 load, 10 accumulate, 11 clear.
- t_acc_out  out  NELEM*DATA_W  tensor accumulator.

Behaviour:
- Reset (async, immediate) values:
  - acc, all GPRs, tensors, t_acc, indices: 0.
  - sp_out = STACK_BASE, stack_empty = 1, stack_full = 0, stack_err = 0, a_full = b_full = 0.
  - Mid-operation reset aborts partial tensor loads.
- Accumulator: updates on the clock edge when acc_wr = 1; otherwise holds.
- GPR write:
  - Takes effect on the edge when gpr_wr = 1.
  - With gpr_src = 0 it captures the pre-edge acc_out, even if acc_wr is high in the same cycle.
- GPR read:
  - Combinational, with write-through bypass: if gpr_wr = 1 and gpr_waddr equals a read address, that port returns the write data in the same cycle.
- Stack:
  - push: sp <= sp-1. pop: sp <= sp+1.
  - stack_empty = (sp == STACK_BASE); stack_full = (STACK_BASE-sp == STACK_DEPTH). Both combinational from sp.
  - push while full or pop while empty: sp unchanged, stack_err <= 1.
  - push and pop in the same cycle: sp unchanged, no error, regardless of flags.
  - stack_err is sticky until err_clr; a new error in the same cycle as err_clr wins (err stays 1).
- Tensor registers (A, B independent):
  - On load_x: element[idx_x] <= dm_out and idx_x increments.
  - At idx = NELEM-1 the index wraps to 0 and x_full <= 1.
  - Any later load_x clears x_full on that edge, and loading continues from element 0.
  - t_clr_idx: idx and full cleared to 0 for both tensors, contents retained; has priority over a simultaneous load (load dropped).
- Tensor accumulator, one-cycle latency:
  - 01: t_acc <= mxu_out.
  - 10: per-lane t_acc[i] <= t_acc[i] + mxu_out[i], computed in DATA_W.
    - SATURATE = 0: modulo 2^DATA_W.
    - SATURATE = 1: signed clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - 11: zero.
  - 00: hold.

Decomposition:
- Package reg_file_pkg:
  - t_acc_mode codes (T_HOLD, T_LOAD, T_ACCUM, T_CLEAR).
  - gpr_src codes (SRC_ACC, SRC_DM).
  - nelem(TDIM) function.
  - Signed saturating-add function.
- Sub-module tensor_loader (element array, index counter, full flag), instantiated for A and B.

Test Plan:
- Reset mid-stream: after 4 load_a, assert reset → a_full = 0, a_out = 0. Next 9 loads of 1..9 → a_out elements 1..9, a_full = 1 on the 9th edge.
- GPR: acc_wr with alu_out = 16'h1234, then gpr_wr src = 0 to R2 while raddr0 = 2 → rdata0 = 16'h1234 in the write cycle (bypass) and after it.
- Stack: push 64 times from 16'hFFFF → sp = 16'hFFBF, full = 1. A 65th push → sp unchanged, err = 1. err_clr → err = 0. Pop at empty → err = 1. push + pop together at full → no change, err unaffected.
- Tensor accumulate, SATURATE = 0: load mxu all 16'h7FFF, then accumulate 16'h0001 → every lane 16'h8000.
- Tensor accumulate, SATURATE = 1: same sequence → every lane 16'h7FFF. Adding 16'h8000 to 16'h8000 → 16'h8000. Mode 11 → all zero.
- t_clr_idx with simultaneous load_b after 3 loads → b_idx = 0, element 3 not written, contents retained.
